tb_run_ctrl: RTL and testbench
==============================

TB_RUN_CTRL -- requirements
Module: tb_run_ctrl

Interface
REQ-001 SHALL have parameter NUM_EXIT, default 1, number of independent exit-report channels (1..8).
REQ-002 SHALL have parameter EXIT_W, default 32, width of each exit value.
REQ-003 SHALL have parameter CNT_W, default 32, width of the cycle counter and the limit.
REQ-004 SHALL have parameter RESET_WAIT_CYCLES, default 50, DUT reset hold length in clk cycles (>=1).
REQ-005 SHALL have parameter WAIT_ALL, default 0: 0 = first exit ends the run; 1 = every channel must exit.
REQ-006 SHALL have clk  input  1  clock; reset rst_n, asynchronous, active-low.
REQ-007 SHALL have boot_sel_i  input  1  boot source: 0 = preload/jtag, 1 = flash.
REQ-008 SHALL have execute_from_flash_i  input  1  flash mode, meaningful only when boot_sel_i=1.
REQ-009 SHALL have max_cycles_i  input  CNT_W  run-cycle limit; 0 = unlimited.
REQ-010 SHALL have load_done_i  input  1  single-cycle pulse from the loader.
REQ-011 SHALL have exit_valid_i  input  NUM_EXIT  per-channel exit strobe.
REQ-012 SHALL have exit_value_i  input  NUM_EXIT*EXIT_W  per-channel exit value, channel k at bits [k*EXIT_W +: EXIT_W].
REQ-013 SHALL have dut_rst_no  output  1  DUT reset, active-low.
REQ-014 SHALL have boot_sel_o, execute_from_flash_o  output  1 each  latched boot configuration.
REQ-015 SHALL have load_req_o  output  1  request to the loader to preload memory.
REQ-016 SHALL have done_o, pass_o, timeout_o  output  1 each  terminal status.
REQ-017 SHALL have fail_chan_o  output  max(1,$clog2(NUM_EXIT))  index of the reporting channel.
REQ-018 SHALL have exit_value_o  output  EXIT_W  reported value; cycle_cnt_o  output  CNT_W  run cycles.

Function
REQ-019 SHALL implement FSM states HOLD, LOAD, RUN, DONE, TIMEOUT.
REQ-020 HOLD: dut_rst_no=0; wait counter increments each cycle; at count RESET_WAIT_CYCLES-1, latch boot_sel_i/execute_from_flash_i (execute forced 0 if boot_sel_i=0), go to LOAD.
REQ-021 dut_rst_no SHALL be registered, rising the first cycle after HOLD exits and staying 1 until rst_n.
REQ-022 LOAD with latched boot_sel=1: transition to RUN next cycle, load_req_o never asserted.
REQ-023 LOAD with boot_sel=0: load_req_o=1 until load_done_i sampled high, then RUN; load_req_o low from the RUN cycle.
REQ-024 RUN: cycle_cnt_o increments by 1 per cycle, starting from 0 on entry, saturating at all-ones.
REQ-025 Exit capture: in RUN each channel's first exit_valid_i pulse sets a sticky flag and captures its value; later pulses on that channel are ignored.
REQ-026 Exit strobes in HOLD, LOAD, DONE, TIMEOUT SHALL be ignored.
REQ-027 Completion: WAIT_ALL=0 -> any flag set; WAIT_ALL=1 -> all flags set; then DONE the next cycle.
REQ-028 Flags and strobes arriving in the same cycle SHALL count toward completion in that cycle.
REQ-029 pass_o=1 if all captured values are zero; else fail_chan_o = lowest-index channel with nonzero value and exit_value_o = its value.
REQ-030 On pass, fail_chan_o = lowest-index captured channel and exit_value_o = 0.
REQ-031 Timeout: in RUN with max_cycles_i!=0 and cycle_cnt_o >= max_cycles_i and completion not met -> TIMEOUT; timeout_o=1, done_o=1, pass_o=0.
REQ-032 Completion and timeout in the same cycle: completion wins.
REQ-033 DONE and TIMEOUT SHALL be terminal until rst_n; all status outputs held stable.
REQ-034 cycle_cnt_o SHALL freeze on leaving RUN.

Reset
REQ-035 rst_n low SHALL force state HOLD, counters 0, flags cleared, dut_rst_no=0, load_req_o=0, done_o=0, pass_o=0, timeout_o=0, fail_chan_o=0, exit_value_o=0, boot_sel_o=0, execute_from_flash_o=0.
REQ-036 rst_n asserted mid-RUN SHALL abort immediately and restart the full HOLD sequence after release.

Structure
REQ-037 SHALL put the state enum and default constants (RESET_WAIT_CYCLES=50, CNT_W=32) in package tb_run_ctrl_pkg.
REQ-038 SHALL use one sub-module tb_exit_merge for the per-channel sticky capture, completion reduction, and lowest-index failure priority.

Verification
REQ-039 NUM_EXIT=1, boot_sel=0: load_done_i at cycle 60, exit value 0 at cycle 100 -> dut_rst_no rises after cycle 50, load_req_o 50..60, done_o=1, pass_o=1.
REQ-040 boot_sel=1, execute=1: no load_req_o; RUN from cycle 51; boot_sel_o=1 and execute_from_flash_o=1 held.
REQ-041 NUM_EXIT=4, WAIT_ALL=1: channels 3,1,0,2 exit with 0,7,0,5 -> done only after the 4th exit; fail_chan_o=1, exit_value_o=7.
REQ-042 max_cycles_i=20, no exit -> timeout_o=1 when cycle_cnt_o reaches 20; an exit on that same cycle instead gives done_o with pass/fail.
REQ-043 rst_n pulsed low mid-RUN -> all outputs return to reset values; full HOLD of 50 cycles repeats.
REQ-044 Exit strobe during HOLD/LOAD plus a repeated strobe with a different value in RUN -> only the first RUN value is reported.

Source files
------------

// File: rtl/tb_run_ctrl_pkg.sv
// Shared types and defaults for the run controller: FSM state encoding and
// parameter defaults used by the controller, its interface and the exit merger.
package tb_run_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } run_state_e;

    localparam int DEF_RESET_WAIT_CYCLES = 50;
    localparam int DEF_CNT_W             = 32;
    localparam int DEF_EXIT_W            = 32;

    // Channel index width; a single channel still needs one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tb_run_ctrl_if.sv
// Loader handshake and per-channel exit reports between the run controller
// (slave) and the environment that drives it (master).
interface tb_run_ctrl_if
    import tb_run_ctrl_pkg::*;
#(
    parameter int NUM_EXIT = 1,
    parameter int EXIT_W   = DEF_EXIT_W
);
    logic                                load_req_o;
    logic                                load_done_i;
    logic [NUM_EXIT-1:0]                 exit_valid_i;
    logic [NUM_EXIT-1:0][EXIT_W-1:0]     exit_value_i;

    modport master (
        input  load_req_o,
        output load_done_i, exit_valid_i, exit_value_i
    );

    modport slave (
        output load_req_o,
        input  load_done_i, exit_valid_i, exit_value_i
    );
endinterface

// File: rtl/tb_exit_merge.sv
// Per-channel sticky exit capture, completion reduction and lowest-index
// failure selection for the run controller.
module tb_exit_merge
    import tb_run_ctrl_pkg::*;
#(
    parameter int NUM_EXIT = 1,
    parameter int EXIT_W   = DEF_EXIT_W,
    parameter int WAIT_ALL = 0,
    localparam int CH_W    = chan_w(NUM_EXIT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [NUM_EXIT-1:0]             exit_valid,
    input  logic [NUM_EXIT-1:0][EXIT_W-1:0] exit_value,
    output logic                            complete,
    output logic                            pass,
    output logic [CH_W-1:0]                 chan,
    output logic [EXIT_W-1:0]               value
);

    logic [NUM_EXIT-1:0]             flag_q;
    logic [NUM_EXIT-1:0]             hit;
    logic [NUM_EXIT-1:0]             flag_eff;
    logic [NUM_EXIT-1:0][EXIT_W-1:0] val_q;
    logic                            fail;
    logic [CH_W-1:0]                 any_idx;
    logic [CH_W-1:0]                 fail_idx;
    logic [EXIT_W-1:0]               fail_val;

    // Only the first strobe per channel is taken; later ones are dropped.
    assign hit = exit_valid & ~flag_q & {NUM_EXIT{en}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
            val_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_EXIT; i++) begin
                if (hit[i]) begin
                    flag_q[i] <= 1'b1;
                    val_q[i]  <= exit_value[i];
                end
            end
        end
    end

    // Strobes landing this cycle count toward completion immediately.
    assign flag_eff = flag_q | hit;
    assign complete = (WAIT_ALL != 0) ? (&flag_eff) : (|flag_eff);

    // Descending scan so the last hit written is the lowest index.
    always_comb begin
        fail     = 1'b0;
        any_idx  = '0;
        fail_idx = '0;
        fail_val = '0;
        for (int i = NUM_EXIT - 1; i >= 0; i--) begin
            if (flag_q[i]) begin
                any_idx = CH_W'(i);
                if (val_q[i] != '0) begin
                    fail     = 1'b1;
                    fail_idx = CH_W'(i);
                    fail_val = val_q[i];
                end
            end
        end
        pass  = ~fail;
        chan  = fail ? fail_idx : any_idx;
        value = fail ? fail_val : '0;
    end

endmodule

// File: rtl/tb_run_ctrl.sv
// Run controller: holds the DUT in reset, latches boot config, optionally
// preloads memory, then runs until exit reports complete or the cycle limit hits.
module tb_run_ctrl
    import tb_run_ctrl_pkg::*;
#(
    parameter int NUM_EXIT          = 1,
    parameter int EXIT_W            = DEF_EXIT_W,
    parameter int CNT_W             = DEF_CNT_W,
    parameter int RESET_WAIT_CYCLES = DEF_RESET_WAIT_CYCLES,
    parameter int WAIT_ALL          = 0,
    localparam int CH_W             = chan_w(NUM_EXIT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               boot_sel_i,
    input  logic               execute_from_flash_i,
    input  logic [CNT_W-1:0]   max_cycles_i,
    tb_run_ctrl_if.slave       bus,
    output logic               dut_rst_no,
    output logic               boot_sel_o,
    output logic               execute_from_flash_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               timeout_o,
    output logic [CH_W-1:0]    fail_chan_o,
    output logic [EXIT_W-1:0]  exit_value_o,
    output logic [CNT_W-1:0]   cycle_cnt_o
);

    localparam int WAIT_W = $clog2(RESET_WAIT_CYCLES + 1);

    run_state_e          state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]    cycle_cnt_q;
    logic                boot_sel_q;
    logic                exec_q;
    logic                dut_rst_q;
    logic                wait_last;
    logic                time_up;
    logic                run_en;
    logic                complete;
    logic                m_pass;
    logic [CH_W-1:0]     m_chan;
    logic [EXIT_W-1:0]   m_value;
    logic                load_req;

    assign wait_last = (wait_cnt_q == WAIT_W'(RESET_WAIT_CYCLES - 1));
    assign time_up   = (max_cycles_i != '0) && (cycle_cnt_q >= max_cycles_i);
    assign run_en    = (state_q == RUN);

    tb_exit_merge #(
        .NUM_EXIT (NUM_EXIT),
        .EXIT_W   (EXIT_W),
        .WAIT_ALL (WAIT_ALL)
    ) u_merge (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (run_en),
        .exit_valid (bus.exit_valid_i),
        .exit_value (bus.exit_value_i),
        .complete   (complete),
        .pass       (m_pass),
        .chan       (m_chan),
        .value      (m_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HOLD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:    if (wait_last) state_d = LOAD;
            LOAD:    if (boot_sel_q || bus.load_done_i) state_d = RUN;
            // Completion is checked first so it beats a simultaneous timeout.
            RUN: begin
                if (complete)     state_d = DONE;
                else if (time_up) state_d = TIMEOUT;
            end
            DONE:    state_d = DONE;
            TIMEOUT: state_d = TIMEOUT;
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            boot_sel_q  <= 1'b0;
            exec_q      <= 1'b0;
            dut_rst_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            if (state_q == HOLD) begin
                if (wait_last) begin
                    boot_sel_q <= boot_sel_i;
                    exec_q     <= boot_sel_i & execute_from_flash_i;
                    dut_rst_q  <= 1'b1;
                end else begin
                    wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                end
            end
            // Count only while staying in RUN so the value freezes at the exit cycle.
            if (state_q == RUN && state_d == RUN && cycle_cnt_q != '1)
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        load_req     = 1'b0;
        done_o       = 1'b0;
        pass_o       = 1'b0;
        timeout_o    = 1'b0;
        fail_chan_o  = '0;
        exit_value_o = '0;
        case (state_q)
            LOAD:    load_req = ~boot_sel_q;
            DONE: begin
                done_o       = 1'b1;
                pass_o       = m_pass;
                fail_chan_o  = m_chan;
                exit_value_o = m_value;
            end
            TIMEOUT: begin
                done_o    = 1'b1;
                timeout_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.load_req_o           = load_req;
    assign dut_rst_no               = dut_rst_q;
    assign boot_sel_o               = boot_sel_q;
    assign execute_from_flash_o     = exec_q;
    assign cycle_cnt_o              = cycle_cnt_q;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Directed bench for tb_run_ctrl: table of single-channel runs plus hand
// sequences for the four-channel wait-all case, stale strobes and mid-run reset.
module tb_tb_run_ctrl;
    import tb_run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_sel = 1'b0;
    logic        exec_fl = 1'b0;
    logic [31:0] max_cyc = '0;

    always #5 clk = ~clk;

    tb_run_ctrl_if #(.NUM_EXIT(1), .EXIT_W(32)) bus0();
    tb_run_ctrl_if #(.NUM_EXIT(4), .EXIT_W(32)) bus4();

    logic        dut_rst0, bso0, exo0, done0, pass0, tmo0;
    logic [0:0]  chan0;
    logic [31:0] val0, cnt0;
    logic        dut_rst4, bso4, exo4, done4, pass4, tmo4;
    logic [1:0]  chan4;
    logic [31:0] val4, cnt4;

    tb_run_ctrl #(.NUM_EXIT(1), .WAIT_ALL(0)) u0 (
        .clk(clk), .rst_n(rst_n), .boot_sel_i(boot_sel), .execute_from_flash_i(exec_fl),
        .max_cycles_i(max_cyc), .bus(bus0), .dut_rst_no(dut_rst0), .boot_sel_o(bso0),
        .execute_from_flash_o(exo0), .done_o(done0), .pass_o(pass0), .timeout_o(tmo0),
        .fail_chan_o(chan0), .exit_value_o(val0), .cycle_cnt_o(cnt0)
    );

    tb_run_ctrl #(.NUM_EXIT(4), .WAIT_ALL(1)) u4 (
        .clk(clk), .rst_n(rst_n), .boot_sel_i(boot_sel), .execute_from_flash_i(exec_fl),
        .max_cycles_i(max_cyc), .bus(bus4), .dut_rst_no(dut_rst4), .boot_sel_o(bso4),
        .execute_from_flash_o(exo4), .done_o(done4), .pass_o(pass4), .timeout_o(tmo4),
        .fail_chan_o(chan4), .exit_value_o(val4), .cycle_cnt_o(cnt4)
    );

    typedef struct {
        string       name;
        logic        bs;
        logic        ex;
        int          maxc;
        int          ld;
        int          exc;
        logic [31:0] exv;
        logic        e_pass;
        logic        e_tmo;
        logic [31:0] e_val;
        int          e_cnt;
        logic        e_exo;
    } vec_t;

    vec_t vt[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_bus();
        bus0.load_done_i  = 1'b0;
        bus0.exit_valid_i = '0;
        bus0.exit_value_i = '0;
        bus4.load_done_i  = 1'b0;
        bus4.exit_valid_i = '0;
        bus4.exit_value_i = '0;
    endtask

    // Leaves the bench 1 time unit after a posedge with rst_n released: cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_bus();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input string nm, input logic bs, input logic ex,
                           input int maxc, input int ld, input int exc, input logic [31:0] exv,
                           input logic e_pass, input logic e_tmo, input logic [31:0] e_val,
                           input int e_cnt, input logic e_exo);
        vt[i] = '{nm, bs, ex, maxc, ld, exc, exv, e_pass, e_tmo, e_val, e_cnt, e_exo};
    endtask

    initial begin
        int bad_lr, bad_rst;

        // name, bs, ex, max, load_done cyc, exit cyc, exit val, pass, tmo, val, cnt, exo
        set_vec(0, "preload_pass",  0, 0,  0, 60, 100, 32'h0,    1, 0, 32'h0,    39, 0);
        set_vec(1, "flash_fail",    1, 1,  0, -1,  80, 32'h1234, 0, 0, 32'h1234, 29, 1);
        set_vec(2, "exec_forced0",  0, 1,  0, 55,  70, 32'h0,    1, 0, 32'h0,    14, 0);
        set_vec(3, "timeout20",     1, 0, 20, -1,  -1, 32'h0,    0, 1, 32'h0,    20, 0);
        set_vec(4, "exit_at_limit", 1, 0, 20, -1,  71, 32'h9,    0, 0, 32'h9,    20, 0);
        set_vec(5, "exit_before",   1, 0, 20, -1,  70, 32'h0,    1, 0, 32'h0,    19, 0);
        set_vec(6, "load_strobe",   0, 0, 10, 58,  55, 32'h5,    0, 1, 32'h0,    10, 0);
        set_vec(7, "limit_one",     1, 0,  1, -1,  -1, 32'h0,    0, 1, 32'h0,     1, 0);

        clear_bus();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dut_rst",  dut_rst0, 0);
        chk("rst_load_req", bus0.load_req_o, 0);
        chk("rst_done",     {done0, pass0, tmo0, done4}, 0);
        chk("rst_cfg",      {bso0, exo0}, 0);
        chk("rst_val_chan", {val0, chan0}, 0);
        chk("rst_cnt",      cnt0, 0);

        foreach (vt[i]) begin
            do_reset();
            boot_sel = vt[i].bs;
            exec_fl  = vt[i].ex;
            max_cyc  = vt[i].maxc;
            bad_lr   = 0;
            bad_rst  = 0;
            for (int c = 0; c < 130; c++) begin
                bus0.load_done_i  = (c == vt[i].ld);
                bus0.exit_valid_i = (c == vt[i].exc);
                bus0.exit_value_i = (c == vt[i].exc) ? vt[i].exv : 32'hDEADBEEF;
                if (bus0.load_req_o !== (!vt[i].bs && c >= 50 && c <= vt[i].ld)) bad_lr++;
                if (dut_rst0 !== (c >= 50)) bad_rst++;
                step();
            end
            clear_bus();
            chk({vt[i].name, "_load_req_cycles"}, bad_lr, 0);
            chk({vt[i].name, "_dut_rst_cycles"}, bad_rst, 0);
            chk({vt[i].name, "_done"},    done0, 1);
            chk({vt[i].name, "_pass"},    pass0, vt[i].e_pass);
            chk({vt[i].name, "_timeout"}, tmo0, vt[i].e_tmo);
            chk({vt[i].name, "_value"},   val0, vt[i].e_val);
            chk({vt[i].name, "_cnt"},     cnt0, vt[i].e_cnt);
            chk({vt[i].name, "_bso"},     bso0, vt[i].bs);
            chk({vt[i].name, "_exo"},     exo0, vt[i].e_exo);
        end

        // Four channels, wait-all: ch3,1,0,2 exit 0,7,0,5; ch1 re-strobes with 3.
        do_reset();
        boot_sel = 1'b1; exec_fl = 1'b0; max_cyc = '0;
        for (int c = 0; c < 80; c++) begin
            bus4.exit_valid_i = '0;
            for (int k = 0; k < 4; k++) bus4.exit_value_i[k] = 32'hDEADBEEF;
            case (c)
                60: begin bus4.exit_valid_i[3] = 1'b1; bus4.exit_value_i[3] = 32'd0; end
                62: begin bus4.exit_valid_i[1] = 1'b1; bus4.exit_value_i[1] = 32'd7; end
                63: begin bus4.exit_valid_i[1] = 1'b1; bus4.exit_value_i[1] = 32'd3; end
                64: begin bus4.exit_valid_i[0] = 1'b1; bus4.exit_value_i[0] = 32'd0; end
                66: begin bus4.exit_valid_i[2] = 1'b1; bus4.exit_value_i[2] = 32'd5; end
                default: ;
            endcase
            if (c == 66) chk("wa_not_done_before_last", done4, 0);
            if (c == 67) chk("wa_done_after_last", done4, 1);
            step();
        end
        clear_bus();
        chk("wa_pass",      pass4, 0);
        chk("wa_fail_chan", chan4, 1);
        chk("wa_value",     val4, 7);
        chk("wa_cnt",       cnt4, 15);
        chk("wa_timeout",   tmo4, 0);

        // Four channels all zero in one cycle -> pass, lowest captured channel.
        do_reset();
        boot_sel = 1'b1;
        for (int c = 0; c < 60; c++) begin
            bus4.exit_valid_i = (c == 55) ? 4'hF : 4'h0;
            bus4.exit_value_i = '0;
            step();
        end
        clear_bus();
        chk("wa0_done", done4, 1);
        chk("wa0_pass", pass4, 1);
        chk("wa0_chan", chan4, 0);
        chk("wa0_cnt",  cnt4, 4);

        // Stale strobes in HOLD and LOAD, then two RUN strobes: only 0x11 counts.
        do_reset();
        boot_sel = 1'b0;
        for (int c = 0; c < 70; c++) begin
            bus0.load_done_i  = (c == 55);
            bus0.exit_valid_i = (c == 10 || c == 52 || c == 60 || c == 61);
            bus0.exit_value_i = (c == 10) ? 32'hAA : (c == 52) ? 32'hBB :
                                (c == 60) ? 32'h11 : 32'h22;
            step();
        end
        clear_bus();
        chk("stale_done",  done0, 1);
        chk("stale_pass",  pass0, 0);
        chk("stale_value", val0, 32'h11);
        chk("stale_cnt",   cnt0, 4);

        // Reset pulse mid-RUN, then full HOLD with a new boot config.
        do_reset();
        boot_sel = 1'b1; exec_fl = 1'b1;
        for (int c = 0; c < 61; c++) begin
            if (c == 51) chk("mid_cnt_start", cnt0, 0);
            step();
        end
        chk("mid_cnt_run", cnt0, 10);
        chk("mid_cfg",     {bso0, exo0}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dut_rst", dut_rst0, 0);
        chk("mid_rst_cfg",     {bso0, exo0}, 0);
        chk("mid_rst_cnt",     cnt0, 0);
        chk("mid_rst_status",  {done0, pass0, tmo0, bus0.load_req_o, chan0, val0}, 0);
        boot_sel = 1'b0; exec_fl = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 56; c++) begin
            if (c == 49) chk("re_hold_dut_rst", dut_rst0, 0);
            if (c == 50) begin
                chk("re_dut_rst_rise", dut_rst0, 1);
                chk("re_load_req",     bus0.load_req_o, 1);
                chk("re_bso",          bso0, 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
